// File: rtl/exe_mem_pipe_reg.sv
// EXE->MEM elastic pipeline stage: head + skid entry, valid/ready handshake, freeze and flush.
// Optional input back-pressure counter enabled by defining EXE_MEM_STALL_CNT_EN.
module exe_mem_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 4,
    parameter int CTRL_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              freeze,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] alu_res_in,
    input  logic [DATA_W-1:0] val_rm_in,
    input  logic [DEST_W-1:0] dest_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [DATA_W-1:0] alu_res_out,
    output logic [DATA_W-1:0] val_rm_out,
    output logic [DEST_W-1:0] dest_out,
    output logic              fwd_wb_en,
    output logic [DEST_W-1:0] fwd_dest,
    output logic [31:0]       stall_cnt
);

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] rm;
        logic [DEST_W-1:0] dest;
    } entry_t;

    // Encoding doubles as the valid bits: bit0 = head valid, bit1 = skid valid.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b11
    } state_t;

    state_t state, state_nx;
    entry_t head, skid, in_ent;
    logic   h_vld, s_vld, in_fire, out_fire;
    logic   load_h_in, load_h_skid, load_s, clr_ctrl;

    assign h_vld     = state[0];
    assign s_vld     = state[1];
    assign in_ready  = ~s_vld & ~freeze;
    assign out_valid = h_vld & ~freeze;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign in_ent    = '{ctrl: ctrl_in, alu: alu_res_in, rm: val_rm_in, dest: dest_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        load_h_in   = 1'b0;
        load_h_skid = 1'b0;
        load_s      = 1'b0;
        clr_ctrl    = 1'b0;
        if (flush) begin
            state_nx = EMPTY;
            clr_ctrl = 1'b1;
        end else begin
            case (state)
                EMPTY: if (in_fire) begin
                    state_nx  = ONE;
                    load_h_in = 1'b1;
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        load_h_in = 1'b1;
                    end else if (in_fire) begin
                        state_nx = TWO;
                        load_s   = 1'b1;
                    end else if (out_fire) begin
                        state_nx = EMPTY;
                    end
                end
                TWO: if (out_fire) begin
                    state_nx    = ONE;
                    load_h_skid = 1'b1;
                end
                default: state_nx = EMPTY;
            endcase
        end
    end

    // Flush only clears control bits; data payload is left in place as a harmless bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            skid <= '0;
        end else if (clr_ctrl) begin
            head.ctrl <= '0;
            skid.ctrl <= '0;
        end else begin
            if (load_h_in)        head <= in_ent;
            else if (load_h_skid) head <= skid;
            if (load_s)           skid <= in_ent;
        end
    end

    assign ctrl_out    = h_vld ? head.ctrl : '0;
    assign alu_res_out = head.alu;
    assign val_rm_out  = head.rm;
    assign dest_out    = head.dest;
    assign fwd_wb_en   = ctrl_out[0] & out_valid;
    assign fwd_dest    = dest_out;

`ifdef EXE_MEM_STALL_CNT_EN
    logic [31:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                       cnt <= '0;
        else if (in_valid && !in_ready && cnt != 32'hFFFF_FFFF) cnt <= cnt + 32'd1;
    end
    assign stall_cnt = cnt;
`else
    assign stall_cnt = '0;
`endif

endmodule
